// File: rtl/calendar_timekeeper.sv
// Prescaled sec/min/hour time-of-day counter with wrapping day count, load, hold and 12h display.
// Define CALENDAR_TIMEKEEPER_ALARM_EN to build the alarm compare; otherwise ALARM is tied low.
module calendar_timekeeper #(
    parameter int unsigned TICK_DIV      = 50_000_000,
    parameter int unsigned SECS_PER_MIN  = 60,
    parameter int unsigned MINS_PER_HOUR = 60,
    parameter int unsigned HOURS_PER_DAY = 24,
    parameter int unsigned FIELD_W       = 6,
    parameter int unsigned DAY_W         = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               HOLD,
    input  logic               LD,
    input  logic [FIELD_W-1:0] LD_H,
    input  logic [FIELD_W-1:0] LD_M,
    input  logic [FIELD_W-1:0] LD_S,
    input  logic               MODE12,
    output logic [FIELD_W-1:0] Hours,
    output logic [FIELD_W-1:0] Mins,
    output logic [FIELD_W-1:0] Secs,
    output logic               PM,
    output logic [DAY_W-1:0]   Days,
    output logic               TICK,
    output logic               DAY_PULSE,
    output logic               LD_ERR,
    input  logic [FIELD_W-1:0] ALM_H,
    input  logic [FIELD_W-1:0] ALM_M,
    input  logic [FIELD_W-1:0] ALM_S,
    input  logic               ALM_ARM,
    output logic               ALARM
);

    localparam int unsigned        CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [FIELD_W-1:0] S_MAX   = FIELD_W'(SECS_PER_MIN - 1);
    localparam logic [FIELD_W-1:0] M_MAX   = FIELD_W'(MINS_PER_HOUR - 1);
    localparam logic [FIELD_W-1:0] H_MAX   = FIELD_W'(HOURS_PER_DAY - 1);
    localparam logic [FIELD_W-1:0] HALF    = FIELD_W'(HOURS_PER_DAY / 2);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FIELD_W-1:0] sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic [DAY_W-1:0]   days_q, days_d;
    logic               tick_q, tick_d, day_pulse_q, day_pulse_d, ld_err_q, ld_err_d;

    logic [FIELD_W-1:0] sec_inc, min_inc, hour_inc;
    logic               sec_wrap, min_wrap, day_wrap, tick_now;

    // Incremented time, as it would look after a tick.
    always_comb begin
        sec_wrap = (sec_q == S_MAX);
        min_wrap = sec_wrap && (min_q == M_MAX);
        day_wrap = min_wrap && (hour_q == H_MAX);
        tick_now = !HOLD && (cnt_q == CNT_MAX);
        sec_inc  = sec_wrap ? '0 : sec_q + 1'b1;
        min_inc  = !sec_wrap ? min_q : ((min_q == M_MAX) ? '0 : min_q + 1'b1);
        hour_inc = !min_wrap ? hour_q : ((hour_q == H_MAX) ? '0 : hour_q + 1'b1);
    end

    always_comb begin
        cnt_d       = cnt_q;
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        days_d      = days_q;
        tick_d      = 1'b0;
        day_pulse_d = 1'b0;
        ld_err_d    = 1'b0;
        if (LD) begin
            cnt_d    = '0;
            sec_d    = (LD_S > S_MAX) ? '0 : LD_S;
            min_d    = (LD_M > M_MAX) ? '0 : LD_M;
            hour_d   = (LD_H > H_MAX) ? '0 : LD_H;
            ld_err_d = (LD_S > S_MAX) || (LD_M > M_MAX) || (LD_H > H_MAX);
        end else if (tick_now) begin
            cnt_d  = '0;
            sec_d  = sec_inc;
            min_d  = min_inc;
            hour_d = hour_inc;
            tick_d = 1'b1;
            if (day_wrap) begin
                days_d      = days_q + 1'b1;
                day_pulse_d = 1'b1;
            end
        end else if (!HOLD) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q       <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            days_q      <= '0;
            tick_q      <= 1'b0;
            day_pulse_q <= 1'b0;
            ld_err_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            days_q      <= days_d;
            tick_q      <= tick_d;
            day_pulse_q <= day_pulse_d;
            ld_err_q    <= ld_err_d;
        end
    end

    // 12h display maps internal hour 0 to HALF (midnight/noon shown as 12).
    always_comb begin
        if (!MODE12) begin
            Hours = hour_q;
        end else if (hour_q == '0) begin
            Hours = HALF;
        end else if (hour_q > HALF) begin
            Hours = hour_q - HALF;
        end else begin
            Hours = hour_q;
        end
    end

    assign Mins      = min_q;
    assign Secs      = sec_q;
    assign PM        = (hour_q >= HALF);
    assign Days      = days_q;
    assign TICK      = tick_q;
    assign DAY_PULSE = day_pulse_q;
    assign LD_ERR    = ld_err_q;

`ifdef CALENDAR_TIMEKEEPER_ALARM_EN
    logic alarm_q, alarm_d;

    // Only a real tick can fire; a load landing on the alarm time is silent.
    always_comb begin
        alarm_d = !LD && tick_now && ALM_ARM &&
                  (hour_inc == ALM_H) && (min_inc == ALM_M) && (sec_inc == ALM_S);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign ALARM = alarm_q;
`else
    logic unused_alm;
    assign unused_alm = ^{ALM_H, ALM_M, ALM_S, ALM_ARM};
    assign ALARM      = 1'b0;
`endif

endmodule
